spi_burst_decoder: RTL
======================

# spi_burst_decoder

Parametrised SPI-to-register-file command decoder for the PWM peripheral. It sits between the SPI slave byte interface and the register bank. It decodes a one-byte command and then serves any number of data bytes in the same chip-select frame. Frames may use auto-increment bursts, address wrap and out-of-range detection. It returns to idle on chip-select deassertion, so back-to-back transactions need no reset.

## Interface
- ADDR_W, 6: register byte-address width; legal 1..6.
- MAX_ADDR, 2**ADDR_W-1: highest implemented byte address; wrap point and range limit.
- clk  in  1  peripheral clock
- rst_n  in  1  reset, asynchronous, active-low
- cs_active  in  1  high while SPI chip-select is asserted (synchronised by SPI slave)
- byte_sync  in  1  one-cycle pulse: data_in holds a complete received byte
- data_in  in  8  byte received from master
- data_out  out  8  byte to be shifted out to master on the next SPI byte
- read  out  1  one-cycle register read strobe
- write  out  1  one-cycle register write strobe
- addr  out  ADDR_W  register byte address, valid while read/write high
- data_read  in  8  register read data, combinational from addr, valid in strobe cycle
- data_write  out  8  write data, valid while write high
- busy  out  1  high from command byte until frame end
- err  out  1  sticky out-of-range flag, cleared by next command byte

## Operation
- Command byte (first byte_sync of a frame): bit7 = 1 write / 0 read; bit6 = INC (auto-increment); bits[ADDR_W-1:0] = start address; unused address bits ignored.
- FSM states: IDLE, WR_DATA, RD_DATA.
  - IDLE + byte_sync → WR_DATA or RD_DATA per bit7; latch address and INC; clear err.
  - WR_DATA/RD_DATA + cs_active low → IDLE. No other exit.
- Write: each byte_sync in WR_DATA writes data_in to the current address. INC=1: address += 1 after the strobe. INC=0: same address rewritten.
- Read: entering RD_DATA issues a read of the start address, then preloads data_out. Each later byte_sync in RD_DATA: INC=1 reads address+1; INC=0 re-reads the same address (status polling).
- Increment at MAX_ADDR wraps to 0. Arithmetic is modulo MAX_ADDR+1.
- Address > MAX_ADDR at access time: no strobe, err←1; for reads data_out←8'h00. Later in-range addresses (after wrap) access normally.
- byte_sync while cs_active low: ignored.
- cs_active falling while a strobe is pending: the pending strobe completes; state goes to IDLE the cycle after.

## Timing
- Reset values: read=0, write=0, addr=0, data_write=0, data_out=0, busy=0, err=0, state IDLE.
- Write latency: byte_sync at cycle N → write=1 at N+1 with registered data_write=data_in(N). Address increments at N+2.
- Read latency: byte_sync at N → read=1 at N+1 → data_out updated at N+2 and held until the next load. Address for the next read increments at N+2 (INC=1).
- Strobes are exactly one cycle. read and write are never high together. addr and data_write are stable for the strobe cycle.
- busy rises at N+1 after the command byte_sync. busy falls the cycle after cs_active low is sampled.
- In IDLE, data_out returns to 0 at the cycle after entry.
- byte_sync pulses are assumed ≥3 cycles apart; a closer pulse is dropped.

## Structure
- Package pwm_spi_pkg: command bit positions (CMD_WR_BIT=7, CMD_INC_BIT=6), state enum, data width constant 8.
- Sub-module burst_addr_ctr (load, increment, wrap at MAX_ADDR, range compare → out_of_range). The FSM and strobe/data registers stay in the top.

## Test plan
- Single write: cs high, bytes 8'h83, 8'h5A; cs low → one write, addr=3, data_write=8'h5A at byte_sync+1; busy falls after cs low.
- Burst read INC: registers 4..6 = 8'h11,8'h22,8'h33; bytes 8'h44, x, x → read strobes at addr 4,5,6; data_out sequence 8'h11,8'h22,8'h33.
- No-INC write: 8'h82, then 8'hA0, 8'hA1 → two writes, both addr=2, final register value 8'hA1.
- Wrap and range: MAX_ADDR=5, ADDR_W=3, write 8'hC5 then 3 data bytes → writes at 5, 0, 1; err=0. Command 8'h87 then 8'hFF → no write, err=1. Next command clears err.
- Frame abort: cs_active low in the cycle after a data byte_sync → write strobe still issued, state IDLE, busy=0. Next frame 8'h01 → read at addr 1 with no reset.
- Async reset mid-burst read → all outputs 0 immediately; no strobe after rst_n rises until a new command byte.

Source files
------------

// File: rtl/pwm_spi_pkg.sv
// Shared definitions for the PWM peripheral SPI command decoder.
// Holds the command byte bit positions, the register data width and the
// decoder state encoding used by spi_burst_decoder.
package pwm_spi_pkg;

  localparam int DATA_W      = 8;
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_INC_BIT = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_DATA = 2'd2
  } state_t;

endpackage

// File: rtl/burst_addr_ctr.sv
// Register byte-address counter for burst transfers.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   load          take load_addr as the new address (priority over incr)
//   load_addr     start address taken from the command byte
//   incr          advance to the next address, wrapping at MAX_ADDR
//   check_load    range-check load_addr instead of the held address
//   addr          current address
//   out_of_range  the address about to be accessed is above MAX_ADDR
module burst_addr_ctr #(
  parameter int ADDR_W   = 6,
  parameter int MAX_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              incr,
  input  logic              check_load,
  output logic [ADDR_W-1:0] addr,
  output logic              out_of_range
);
  import pwm_spi_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MAX_ADDR);

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] check_addr;

  // Wrap only exactly at MAX_ADDR; an address above it steps on normally
  // until the natural counter overflow brings it back into range.
  assign next_addr  = (addr == LAST) ? '0 : addr + ADDR_W'(1);

  // A command read accesses the address in the same cycle it is loaded,
  // so the range compare must look at the incoming value then.
  assign check_addr   = check_load ? load_addr : addr;
  assign out_of_range = int'(check_addr) > MAX_ADDR;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_addr;
    end else if (incr) begin
      addr <= next_addr;
    end
  end

endmodule

// File: rtl/spi_burst_decoder.sv
// SPI-to-register-file command decoder for the PWM peripheral.
// The first byte of a chip-select frame is a command (bit7 write, bit6
// auto-increment, low bits start address); every later byte in the frame
// writes data_in or reads the next register into data_out.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   cs_active     chip-select asserted (already synchronised)
//   byte_sync     one-cycle pulse, data_in holds a received byte
//   data_in       received byte
//   data_out      byte returned to the master on the next SPI byte
//   read, write   one-cycle register strobes
//   addr          register address, valid with the strobes
//   data_read     combinational register read data for addr
//   data_write    register write data, valid with write
//   busy          a frame is in progress
//   err           sticky out-of-range flag, cleared by the next command
module spi_burst_decoder
  import pwm_spi_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int MAX_ADDR = (1 << ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              busy,
  output logic              err
);

  state_t state_q, state_d;
  logic   inc_q, inc_d;
  logic   read_d, write_d, err_d, zero_d;
  logic   take, load, access;
  logic   acc_q, gap1_q, gap2_q, zero_q;
  logic   out_of_range;

  // A byte is accepted only inside a frame and at least three cycles after
  // the previous accepted byte; closer pulses are dropped.
  assign take = cs_active & byte_sync & ~gap1_q & ~gap2_q;
  assign load = take & (state_q == IDLE);
  assign busy = (state_q != IDLE);

  // The counter steps the cycle after every access attempt, including
  // out-of-range ones, so a burst can wrap back into the implemented range.
  burst_addr_ctr #(
    .ADDR_W   (ADDR_W),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .load_addr    (data_in[ADDR_W-1:0]),
    .incr         (acc_q & inc_q),
    .check_load   (state_q == IDLE),
    .addr         (addr),
    .out_of_range (out_of_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inc_q   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      err     <= err_d;
    end
  end

  // Only a chip-select drop leaves a data state. The command byte of a read
  // frame is itself an access of the start address.
  always_comb begin
    state_d = state_q;
    inc_d   = inc_q;
    err_d   = err;
    read_d  = 1'b0;
    write_d = 1'b0;
    zero_d  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          inc_d = data_in[CMD_INC_BIT];
          err_d = 1'b0;
          if (data_in[CMD_WR_BIT]) begin
            state_d = WR_DATA;
          end else begin
            state_d = RD_DATA;
            access  = 1'b1;
          end
        end
      end
      WR_DATA, RD_DATA: begin
        if (!cs_active) begin
          state_d = IDLE;
        end else if (take) begin
          access = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (access) begin
      if (out_of_range) begin
        err_d  = 1'b1;
        zero_d = (state_d == RD_DATA);
      end else begin
        read_d  = (state_d == RD_DATA);
        write_d = (state_d == WR_DATA);
      end
    end
  end

  // A strobe issued just before chip-select drops still completes, and the
  // read data is still captured before data_out is cleared in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read       <= 1'b0;
      write      <= 1'b0;
      acc_q      <= 1'b0;
      gap1_q     <= 1'b0;
      gap2_q     <= 1'b0;
      zero_q     <= 1'b0;
      data_write <= '0;
      data_out   <= '0;
    end else begin
      read   <= read_d;
      write  <= write_d;
      acc_q  <= access;
      gap1_q <= take;
      gap2_q <= gap1_q;
      zero_q <= zero_d;
      if (write_d) begin
        data_write <= data_in;
      end
      if (read) begin
        data_out <= data_read;
      end else if (zero_q || state_q == IDLE) begin
        data_out <= '0;
      end
    end
  end

endmodule
